// File: rtl/time_set_ctrl.sv
// Set-mode controller for the four BCD alarm-clock time digits (mode/up buttons, per-digit load strobes).
// Optional HOLD_REPEAT_EN: a held up button auto-repeats after 256 cycles, then every 64 cycles.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic [3:0] hr_t_q,
  input  logic [3:0] hr_o_q,
  input  logic [3:0] min_t_q,
  input  logic [3:0] min_o_q,
  output logic       set_hr_t,
  output logic       set_hr_o,
  output logic       set_min_t,
  output logic       set_min_o,
  output logic [3:0] new_val,
  output logic       run_en,
  output logic [3:0] digit_sel
);

  typedef enum logic [2:0] {RUN, S_HR_T, S_HR_O, S_MIN_T, S_MIN_O} state_t;

  state_t          state, state_nx;
  logic            mode_d, up_d;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            clamp_pend, clamp_nx;
  logic            up_defer, defer_nx;
  logic [3:0]      strb_nx, val_nx, dsel_nx;
  logic            mode_edge, up_edge, up_evt, do_up, in_set, rep, timed_out;
  logic [3:0]      cur, lim, inc;

  assign mode_edge = mode_btn & ~mode_d;
  assign up_edge   = up_btn & ~up_d;
  assign in_set    = (state != RUN);
  assign up_evt    = up_edge | rep;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef HOLD_REPEAT_EN
  logic       hold_act;
  logic [8:0] hold_cnt;

  assign rep = hold_act & up_btn & in_set & (hold_cnt == 9'd255);

  // After the first repeat the counter reloads to 192 so later repeats come every 64 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_act <= 1'b0;
      hold_cnt <= '0;
    end else if (mode_edge || !up_btn || !in_set) begin
      hold_act <= 1'b0;
    end else if (up_edge) begin
      hold_act <= 1'b1;
      hold_cnt <= '0;
    end else if (hold_act) begin
      hold_cnt <= (hold_cnt == 9'd255) ? 9'd192 : hold_cnt + 9'd1;
    end
  end
`else
  assign rep = 1'b0;
`endif

  always_comb begin
    cur = min_o_q;
    lim = 4'd9;
    case (state)
      S_HR_T:  begin cur = hr_t_q;  lim = 4'd2; end
      S_HR_O:  begin cur = hr_o_q;  lim = (hr_t_q == 4'd2) ? 4'd3 : 4'd9; end
      S_MIN_T: begin cur = min_t_q; lim = 4'd5; end
      default: begin cur = min_o_q; lim = 4'd9; end
    endcase
    inc = (cur >= lim) ? '0 : cur + 4'd1;
  end

  always_comb begin
    strb_nx  = '0;
    val_nx   = '0;
    clamp_nx = 1'b0;
    defer_nx = 1'b0;
    do_up    = (up_evt | up_defer) & ~mode_edge & in_set;

    // A pending clamp owns this cycle's strobe; any up action slips by one cycle.
    if (clamp_pend) begin
      strb_nx  = 4'b0100;
      val_nx   = 4'd3;
      defer_nx = do_up;
    end else if (do_up) begin
      val_nx = inc;
      case (state)
        S_HR_T:  strb_nx = 4'b1000;
        S_HR_O:  strb_nx = 4'b0100;
        S_MIN_T: strb_nx = 4'b0010;
        default: strb_nx = 4'b0001;
      endcase
      clamp_nx = (state == S_HR_T) && (inc == 4'd2) && (hr_o_q > 4'd3);
    end

    state_nx = state;
    if (mode_edge) begin
      case (state)
        RUN:     state_nx = S_HR_T;
        S_HR_T:  state_nx = S_HR_O;
        S_HR_O:  state_nx = S_MIN_T;
        S_MIN_T: state_nx = S_MIN_O;
        default: state_nx = RUN;
      endcase
    end else if (in_set && timed_out && !up_evt) begin
      state_nx = RUN;
    end

    to_cnt_nx = (mode_edge || up_evt || state_nx == RUN) ? '0 : to_cnt + 1'b1;

    case (state_nx)
      S_HR_T:  dsel_nx = 4'b1000;
      S_HR_O:  dsel_nx = 4'b0100;
      S_MIN_T: dsel_nx = 4'b0010;
      S_MIN_O: dsel_nx = 4'b0001;
      default: dsel_nx = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      mode_d     <= 1'b1;
      up_d       <= 1'b1;
      to_cnt     <= '0;
      clamp_pend <= 1'b0;
      up_defer   <= 1'b0;
      set_hr_t   <= 1'b0;
      set_hr_o   <= 1'b0;
      set_min_t  <= 1'b0;
      set_min_o  <= 1'b0;
      new_val    <= '0;
      run_en     <= 1'b1;
      digit_sel  <= '0;
    end else begin
      state      <= state_nx;
      mode_d     <= mode_btn;
      up_d       <= up_btn;
      to_cnt     <= to_cnt_nx;
      clamp_pend <= clamp_nx;
      up_defer   <= defer_nx;
      set_hr_t   <= strb_nx[3];
      set_hr_o   <= strb_nx[2];
      set_min_t  <= strb_nx[1];
      set_min_o  <= strb_nx[0];
      new_val    <= val_nx;
      run_en     <= (state_nx == RUN);
      digit_sel  <= dsel_nx;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against a behavioural model of the set-mode rules.
module tb_time_set_ctrl;
`ifdef HOLD_REPEAT_EN
  localparam int T = 600;
`else
  localparam int T = 40;
`endif

  logic       clk = 1'b0;
  logic       reset, mode_btn, up_btn;
  logic [3:0] hr_t_q, hr_o_q, min_t_q, min_o_q;
  logic       set_hr_t, set_hr_o, set_min_t, set_min_o, run_en;
  logic [3:0] new_val, digit_sel;

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .up_btn(up_btn),
    .hr_t_q(hr_t_q), .hr_o_q(hr_o_q), .min_t_q(min_t_q), .min_o_q(min_o_q),
    .set_hr_t(set_hr_t), .set_hr_o(set_hr_o), .set_min_t(set_min_t), .set_min_o(set_min_o),
    .new_val(new_val), .run_en(run_en), .digit_sel(digit_sel)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: sel 0 = RUN, 1..4 = digit index + 1 in display order.
  int         m_sel, m_tcnt, m_hk;
  bit         m_clamp, m_defer, m_mp, m_up;
  logic [3:0] e_strb, e_val, e_dsel;
  logic       e_run;
  logic [3:0] d [4];
  logic [3:0] pend_strb, pend_val, o_strb, o_val;

  function automatic int lim_of(input int idx, input int ht);
    case (idx)
      0: return 2;
      1: return (ht == 2) ? 3 : 9;
      2: return 5;
      default: return 9;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] q [4];
    bit me, ue, rep, evt, act, nclamp, ndefer;
    int nsel, idx, cur;
    if (reset) begin
      m_sel = 0; m_tcnt = 0; m_clamp = 0; m_defer = 0; m_mp = 1; m_up = 1; m_hk = -1;
      e_strb = 0; e_val = 0; e_run = 1; e_dsel = 0;
      return;
    end
    q[0] = hr_t_q; q[1] = hr_o_q; q[2] = min_t_q; q[3] = min_o_q;
    me = mode_btn && !m_mp;
    ue = up_btn && !m_up;
    rep = 0;
`ifdef HOLD_REPEAT_EN
    if (m_hk >= 0 && up_btn && m_sel != 0) begin
      m_hk++;
      rep = (m_hk >= 256) && ((m_hk - 256) % 64 == 0);
    end
    if (ue && m_sel != 0 && !me) m_hk = 0;
    else if (!up_btn || me || m_sel == 0) m_hk = -1;
`endif
    evt = ue || rep;
    act = (evt || m_defer) && !me && m_sel != 0;
    nclamp = 0; ndefer = 0; e_strb = 0; e_val = 0;
    if (m_clamp) begin
      e_strb = 4'b0100; e_val = 3; ndefer = act;
    end else if (act) begin
      idx = m_sel - 1;
      cur = q[idx];
      e_val = (cur >= lim_of(idx, hr_t_q)) ? 4'd0 : 4'(cur + 1);
      e_strb = 4'b1000 >> idx;
      nclamp = (idx == 0) && (e_val == 2) && (q[1] > 3);
    end
    if (me) nsel = (m_sel + 1) % 5;
    else if (m_sel != 0 && m_tcnt == T - 1 && !evt) nsel = 0;
    else nsel = m_sel;
    m_tcnt = (me || evt || nsel == 0) ? 0 : m_tcnt + 1;
    m_sel = nsel; m_clamp = nclamp; m_defer = ndefer;
    m_mp = mode_btn; m_up = up_btn;
    e_run = (nsel == 0);
    e_dsel = (nsel == 0) ? 4'b0 : (4'b1000 >> (nsel - 1));
  endtask

  // One clock: drive digits from the modelled digit registers, predict, clock, compare.
  task automatic cycle();
    hr_t_q = d[0]; hr_o_q = d[1]; min_t_q = d[2]; min_o_q = d[3];
    model_step();
    @(posedge clk);
    #1;
    o_strb = {set_hr_t, set_hr_o, set_min_t, set_min_o};
    o_val  = new_val;
    check("strobes", 16'(o_strb), 16'(e_strb));
    check("new_val", 16'(o_val), 16'(e_val));
    check("run_en", 16'(run_en), 16'(e_run));
    check("digit_sel", 16'(digit_sel), 16'(e_dsel));
    for (int i = 0; i < 4; i++) if (pend_strb[3-i]) d[i] = pend_val;
    pend_strb = o_strb;
    pend_val  = o_val;
  endtask

  task automatic press_mode();
    mode_btn = 1; cycle();
    mode_btn = 0; cycle();
  endtask

  task automatic press_up(input logic [3:0] exp_strb, input logic [3:0] exp_val, input string tag);
    up_btn = 1; cycle();
    check({tag, "_strb"}, 16'(o_strb), 16'(exp_strb));
    check({tag, "_val"}, 16'(o_val), 16'(exp_val));
    up_btn = 0; cycle();
  endtask

  initial begin
    int cnt;
    pend_strb = 0; pend_val = 0;
    for (int i = 0; i < 4; i++) d[i] = 0;
    reset = 1; mode_btn = 1; up_btn = 0;
    cycle(); cycle();
    check("rst_run_en", 16'(run_en), 16'd1);
    check("rst_dsel", 16'(digit_sel), 16'd0);
    reset = 0; cycle();
    mode_btn = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("idle_run_en", 16'(run_en), 16'd1);
    check("idle_dsel", 16'(digit_sel), 16'd0);

    // hour-tens wrap 0->1->2->0 with feedback
    press_mode();
    check("sel_hrt", 16'(digit_sel), 16'b1000);
    check("run_off", 16'(run_en), 16'd0);
    press_up(4'b1000, 4'd1, "hrt1"); cycle();
    press_up(4'b1000, 4'd2, "hrt2"); cycle();
    press_up(4'b1000, 4'd0, "hrt0"); cycle();

    // hour clamp: loading 2 with hr_o=8 forces hr_o to 3 next cycle
    d[0] = 1; d[1] = 8;
    up_btn = 1; cycle();
    check("clamp_hrt_strb", 16'(o_strb), 16'b1000);
    check("clamp_hrt_val", 16'(o_val), 16'd2);
    up_btn = 0; cycle();
    check("clamp_hro_strb", 16'(o_strb), 16'b0100);
    check("clamp_hro_val", 16'(o_val), 16'd3);
    cycle(); cycle();

    // minute wraps
    press_mode(); press_mode();
    d[2] = 5;
    press_up(4'b0010, 4'd0, "mint_wrap"); cycle();
    press_mode();
    d[3] = 9;
    press_up(4'b0001, 4'd0, "mino_wrap"); cycle();
    press_mode();
    check("back_run", 16'(run_en), 16'd1);

    // timeout from S_HR_O
    press_mode(); mode_btn = 1; cycle(); mode_btn = 0;
    for (int i = 1; i <= T; i++) begin
      cycle();
      if (i >= T - 1) check("timeout_run_en", 16'(run_en), 16'(i == T));
    end

    // reset mid-wait, then a full timeout again
    press_mode();
    for (int i = 0; i < 10; i++) cycle();
    reset = 1; cycle();
    check("midrst_run_en", 16'(run_en), 16'd1);
    check("midrst_dsel", 16'(digit_sel), 16'd0);
    reset = 0; cycle();
    mode_btn = 1; cycle(); mode_btn = 0;
    for (int i = 1; i <= T; i++) begin
      cycle();
      if (i >= T - 1) check("timeout2_run_en", 16'(run_en), 16'(i == T));
    end

    // simultaneous mode+up in S_MIN_T
    press_mode(); press_mode(); press_mode();
    check("sel_mint", 16'(digit_sel), 16'b0010);
    mode_btn = 1; up_btn = 1; cycle();
    check("both_strb", 16'(o_strb), 16'd0);
    check("both_sel", 16'(digit_sel), 16'b0001);
    mode_btn = 0; up_btn = 0; cycle();

`ifdef HOLD_REPEAT_EN
    cnt = 0;
    up_btn = 1;
    for (int i = 0; i < 256 + 100; i++) begin
      cycle();
      if (o_strb != 0) cnt++;
    end
    up_btn = 0; cycle();
    check("hold_repeats", 16'(cnt), 16'd3);
`endif

    // randomized bursts, including long quiet stretches that reach the timeout
    for (int b = 0; b < 400; b++) begin
      cnt = $urandom_range(1, 12);
      if ($urandom_range(0, 15) == 0) cnt = T + 5;
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 80) == 0);
      mode_btn = ($urandom_range(0, 3) == 0);
      up_btn = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < cnt; i++) begin
        cycle();
        reset = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
